// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in, parallel-out receiver.
package sipo_pkg;

    // Default word length in bits.
    localparam int WIDTH_DEFAULT = 4;

    // Receiver FSM: waiting for a start tick, or collecting the bits of a word.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : sipo_pkg

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver. Collects WIDTH bits LSB first on enabled
// ticks and presents each completed word on data_o with a valid/ack handshake.
//
// Handshake: data_o holds a word while valid_o is high. The consumer takes it
// by raising ack_i; valid_o drops on that edge unless a new word commits on
// the same edge. A word that completes while valid_o is high and ack_i is low
// is dropped and overrun_o latches until reset.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             serial_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shifted;
    logic             done;
    logic             commit;

    // New bits enter at the top so the first bit received ends up in bit 0.
    assign shifted = {serial_i, shreg[WIDTH-1:1]};

    // The word completes on the tick that samples its last bit.
    assign done   = (state == SHIFT) && tick_i && (cnt == CNT_LAST);
    assign commit = done && (!valid_o || ack_i);

    // busy_o is a pure decode of the registered state, so it carries no input path.
    assign busy_o = (state == SHIFT);

    // Frame sequencing: start detection, bit shifting and bit counting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (tick_i) begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        shreg[WIDTH-1] <= serial_i;
                        cnt            <= CNT_ONE;
                        state          <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= shifted;
                    cnt   <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output word, handshake and sticky overrun flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (commit) begin
                data_o  <= shifted;
                valid_o <= 1'b1;
            end else if (valid_o && ack_i) begin
                valid_o <= 1'b0;
            end
            if (done && valid_o && !ack_i) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer with WIDTH = 4.
module tb_sipo_deserializer;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         tick;
  logic         start;
  logic         serial;
  logic         ack;
  logic [W-1:0] data;
  logic         valid;
  logic         busy;
  logic         overrun;

  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .tick_i    (tick),
    .start_i   (start),
    .serial_i  (serial),
    .ack_i     (ack),
    .data_o    (data),
    .valid_o   (valid),
    .busy_o    (busy),
    .overrun_o (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  // drivers: inputs change 1 time unit after the edge, outputs are sampled there too
  task automatic step(input logic t, input logic s, input logic d, input logic a);
    tick = t; start = s; serial = d; ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic ack_last);
    for (int i = 0; i < W; i++)
      step(1'b1, i == 0, w[i], (i == W - 1) ? ack_last : 1'b0);
    ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // scoreboard pop and compare against data_o / valid_o
  task automatic check_word(input string name);
    logic [W-1:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, data_o=%h", name, data);
    end else begin
      e = exp_q.pop_front();
      if (data !== e || valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s: data_o=%h valid_o=%b, want data_o=%h valid_o=1", name, data, valid, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ack = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick = 1'($urandom_range(0, 1)); serial = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    n_tests++;
    if ({data, valid, busy, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: data=%h valid=%b busy=%b overrun=%b, want all 0", data, valid, busy, overrun);
    end
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: busy=%b valid=%b, want 0 0", busy, valid);
    end
  endtask

  task automatic test_basic();
    logic [3:0] bits;
    int busy_cnt;
    bits = 4'b1101;
    exp_q.push_back(bits);
    busy_cnt = 0;
    for (int i = 0; i < W; i++) begin
      step(1'b1, i == 0, bits[i], 1'b0);
      if (busy === 1'b1) busy_cnt++;
    end
    check_word("basic_word");
    n_tests++;
    if (busy_cnt != 3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: busy cycles=%0d final busy=%b, want 3 and 0", busy_cnt, busy);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (valid !== 1'b0 || data !== 4'b1101) begin
      n_fail++;
      $display("FAIL basic_ack: valid=%b data=%h, want 0 d", valid, data);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_when_idle: valid=%b, want 0", valid);
    end
  endtask

  task automatic test_gated();
    logic [3:0] w;
    logic t;
    w = 4'hA;
    exp_q.push_back(w);
    for (int i = 0; i < 16; i++) begin
      t = (i % 4 == 0);
      step(t, i == 0, t ? w[i/4] : ~w[0], 1'b0);
      n_tests++;
      if (busy !== (i < 12) || valid !== (i >= 12)) begin
        n_fail++;
        $display("FAIL gated_cycle%0d: busy=%b valid=%b, want %b %b", i, busy, valid, i < 12, i >= 12);
      end
    end
    check_word("gated_word");
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    exp_q.push_back(4'h3);
    send_word(4'h3, 1'b0);
    check_word("overrun_first");
    send_word(4'hC, 1'b0);
    n_tests++;
    if (data !== 4'h3 || valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_drop: data=%h valid=%b overrun=%b, want 3 1 1", data, valid, overrun);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: valid=%b overrun=%b, want 0 1", valid, overrun);
    end
  endtask

  task automatic test_ack_commit();
    do_reset();
    n_tests++;
    if (overrun !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clears: overrun=%b valid=%b, want 0 0", overrun, valid);
    end
    exp_q.push_back(4'h6);
    send_word(4'h6, 1'b0);
    check_word("ackc_first");
    exp_q.push_back(4'h5);
    send_word(4'h5, 1'b1);
    check_word("ackc_second");
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ackc_overrun: overrun=%b, want 0", overrun);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();
    n_tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: busy=%b valid=%b, want 0 0", busy, valid);
    end
    exp_q.push_back(4'h9);
    send_word(4'h9, 1'b0);
    check_word("midreset_word");
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    for (int k = 0; k < 8; k++) begin
      w = W'($urandom_range(0, (1 << W) - 1));
      exp_q.push_back(w);
      send_word(w, k > 0);
      check_word("b2b_word");
    end
    // start on the completing tick must not open a new frame
    exp_q.push_back(4'hE);
    for (int i = 0; i < W; i++)
      step(1'b1, (i == 0) || (i == W - 1), 4'hE >> i, 1'b1);
    check_word("start_on_done_word");
    step(1'b1, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_on_done: busy=%b, want 0", busy);
    end
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_overrun: overrun=%b, want 0", overrun);
    end
  endtask

  task automatic test_end_to_end();
    logic [3:0] up_reg;
    // upstream load cycle, then start one tick later with q_o = bit 0
    up_reg = 4'b0110;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(4'b0110);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, up_reg[0], 1'b0);
      up_reg = up_reg >> 1;
    end
    check_word("end_to_end");
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; serial = 1'b0; ack = 1'b0;
    test_reset();
    test_basic();
    test_gated();
    test_overrun();
    test_ack_commit();
    test_reset_mid();
    test_back_to_back();
    test_end_to_end();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d words left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sipo_deserializer
